// File: rtl/regfile_pkg.sv
// regfile_pkg: shared PC select encodings, status flag positions and parameter defaults for pipe_regfile.
package regfile_pkg;
  localparam int DATA_W_DEF   = 32;
  localparam int NUM_REGS_DEF = 16;
  localparam int NUM_RD_DEF   = 4;
  localparam int PC_W_DEF     = 7;
  localparam int RESET_PC_DEF = 0;
  localparam bit BYPASS_DEF   = 1'b1;
  localparam int FLAG_N = 31;
  localparam int FLAG_Z = 30;
  localparam int FLAG_C = 29;
  localparam int FLAG_V = 28;
  typedef enum logic [1:0] {
    PC_INC    = 2'b00,
    PC_START  = 2'b01,
    PC_BRANCH = 2'b11
  } sel_pc_e;
endpackage

// File: rtl/pipe_regfile_if.sv
// pipe_regfile_if: write, load-tracking, read, PC, status and debug signals of pipe_regfile.
interface pipe_regfile_if
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int PC_W     = PC_W_DEF
);
  localparam int AW = $clog2(NUM_REGS);
  logic                     w_en1;
  logic [AW-1:0]            w_addr1;
  logic [DATA_W-1:0]        w_data1;
  logic                     w_en_ldr;
  logic [AW-1:0]            w_addr_ldr;
  logic [DATA_W-1:0]        w_data_ldr;
  logic                     ldr_issue;
  logic [AW-1:0]            ldr_issue_addr;
  logic [NUM_RD*AW-1:0]     rd_addr;
  logic [NUM_RD-1:0]        rd_used;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     hazard;
  logic                     load_pc;
  logic [1:0]               sel_pc;
  logic [PC_W-1:0]          start_pc;
  logic [PC_W-1:0]          dp_pc;
  logic [PC_W-1:0]          pc_out;
  logic                     en_status;
  logic [3:0]               status_mask;
  logic [DATA_W-1:0]        status_in;
  logic [DATA_W-1:0]        status_out;
  logic [AW:0]              dbg_addr;
  logic [DATA_W-1:0]        dbg_data;
  modport master (
    output w_en1, w_addr1, w_data1, w_en_ldr, w_addr_ldr, w_data_ldr, ldr_issue, ldr_issue_addr,
           rd_addr, rd_used, load_pc, sel_pc, start_pc, dp_pc, en_status, status_mask, status_in, dbg_addr,
    input  rd_data, rd_busy, hazard, pc_out, status_out, dbg_data
  );
  modport slave (
    input  w_en1, w_addr1, w_data1, w_en_ldr, w_addr_ldr, w_data_ldr, ldr_issue, ldr_issue_addr,
           rd_addr, rd_used, load_pc, sel_pc, start_pc, dp_pc, en_status, status_mask, status_in, dbg_addr,
    output rd_data, rd_busy, hazard, pc_out, status_out, dbg_data
  );
endinterface

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending-load bits; a set on the same edge as a clear of one address wins.
module reg_scoreboard #(
  parameter int AW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_en,
  input  logic [AW-1:0]     set_addr,
  input  logic              clr_en,
  input  logic [AW-1:0]     clr_addr,
  output logic [2**AW-1:0]  busy
);
  localparam int N = 2**AW;
  logic [N-1:0] set_m, clr_m;
  assign set_m = N'(set_en) << set_addr;
  assign clr_m = N'(clr_en) << clr_addr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) busy <= '0;
    else busy <= (busy & ~clr_m) | set_m;
endmodule

// File: rtl/pipe_regfile.sv
// pipe_regfile: register file with ALU and load write ports, load scoreboard, PC sequencer,
// masked status register and debug read; the top index reads back as the PC.
module pipe_regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int PC_W     = PC_W_DEF,
  parameter int RESET_PC = RESET_PC_DEF,
  parameter bit BYPASS   = BYPASS_DEF
) (
  input logic           clk,
  input logic           rst_n,
  pipe_regfile_if.slave bus
);
  localparam int AW = $clog2(NUM_REGS);
  localparam logic [AW-1:0] PC_IDX = AW'(NUM_REGS - 1);
  localparam logic [AW:0] DBG_PC = {1'b0, PC_IDX};
  localparam logic [AW:0] DBG_ST = DBG_PC + 1'b1;
  logic [DATA_W-1:0] regs [2**AW];
  logic [2**AW-1:0]  busy;
  logic [PC_W-1:0]   pc, pc_d;
  logic [DATA_W-1:0] status, status_d;
  logic              w1_ok, wl_ok;
  assign w1_ok = bus.w_en1 && bus.w_addr1 < PC_IDX;
  assign wl_ok = bus.w_en_ldr && bus.w_addr_ldr < PC_IDX;
  reg_scoreboard #(.AW(AW)) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (bus.ldr_issue && bus.ldr_issue_addr < PC_IDX),
    .set_addr (bus.ldr_issue_addr),
    .clr_en   (bus.w_en_ldr),
    .clr_addr (bus.w_addr_ldr),
    .busy     (busy)
  );
  // Load port is written last so it wins a same-address collision
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) regs <= '{default: '0};
    else begin
      if (w1_ok) regs[bus.w_addr1] <= bus.w_data1;
      if (wl_ok) regs[bus.w_addr_ldr] <= bus.w_data_ldr;
    end
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0] a;
    assign a = bus.rd_addr[i*AW +: AW];
    assign bus.rd_data[i*DATA_W +: DATA_W] =
      a == PC_IDX                            ? DATA_W'(pc)    :
      BYPASS && wl_ok && a == bus.w_addr_ldr ? bus.w_data_ldr :
      BYPASS && w1_ok && a == bus.w_addr1    ? bus.w_data1    : regs[a];
    assign bus.rd_busy[i] = busy[a] & bus.rd_used[i];
  end
  assign bus.hazard = |bus.rd_busy;
  // Redirects ignore the stall; only the increment waits on a hazard
  always_comb begin
    pc_d = !bus.load_pc                ? pc           :
           bus.sel_pc == PC_START      ? bus.start_pc :
           bus.sel_pc == PC_BRANCH     ? bus.dp_pc    :
           bus.hazard                  ? pc           : pc + 1'b1;
    status_d = {(bus.status_mask & bus.status_in[DATA_W-1 -: 4]) | (~bus.status_mask & status[DATA_W-1 -: 4]),
                bus.status_in[DATA_W-5:0]};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc     <= PC_W'(RESET_PC);
      status <= '0;
    end else begin
      pc <= pc_d;
      if (bus.en_status) status <= status_d;
    end
  assign bus.pc_out     = pc;
  assign bus.status_out = status;
  assign bus.dbg_data   = bus.dbg_addr < DBG_PC  ? regs[bus.dbg_addr[AW-1:0]] :
                          bus.dbg_addr == DBG_PC ? DATA_W'(pc)               :
                          bus.dbg_addr == DBG_ST ? status                    : '0;
endmodule

// File: tb/tb_pipe_regfile.sv
// tb_pipe_regfile: directed scenarios plus randomized traffic checked against an array-based model.
module tb_pipe_regfile;
  import regfile_pkg::*;
  localparam int AW  = 4;
  localparam int NR  = 16;
  localparam int PCM = 128;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  logic [31:0] m_reg [NR];
  bit          m_busy [NR];
  int          m_pc;
  logic [31:0] m_st;
  pipe_regfile_if bus ();
  pipe_regfile dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  function automatic int ra(int i);
    return int'(bus.rd_addr[i*AW +: AW]);
  endfunction

  // Architectural read: PC at the top index, else same-cycle write data (load first), else stored value
  function automatic logic [31:0] m_read(int a);
    if (a == NR - 1) return 32'(m_pc);
    if (bus.w_en_ldr && int'(bus.w_addr_ldr) == a) return bus.w_data_ldr;
    if (bus.w_en1 && int'(bus.w_addr1) == a) return bus.w_data1;
    return m_reg[a];
  endfunction

  function automatic bit m_hazard();
    for (int i = 0; i < 4; i++) if (bus.rd_used[i] && m_busy[ra(i)]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_dbg(int a);
    if (a < NR - 1) return m_reg[a];
    if (a == NR - 1) return 32'(m_pc);
    if (a == NR) return m_st;
    return 32'h0;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rd_data%0d", i), 64'(bus.rd_data[i*32 +: 32]), 64'(m_read(ra(i))));
      check($sformatf("rd_busy%0d", i), 64'(bus.rd_busy[i]), 64'(bus.rd_used[i] && m_busy[ra(i)]));
    end
    check("hazard", 64'(bus.hazard), 64'(m_hazard()));
    check("pc_out", 64'(bus.pc_out), 64'(m_pc));
    check("status_out", 64'(bus.status_out), 64'(m_st));
    check("dbg_data", 64'(bus.dbg_data), 64'(m_dbg(int'(bus.dbg_addr))));
  endtask

  task automatic model_reset();
    for (int a = 0; a < NR; a++) begin
      m_reg[a] = '0;
      m_busy[a] = 1'b0;
    end
    m_pc = RESET_PC_DEF;
    m_st = '0;
  endtask

  task automatic model_edge();
    bit hz;
    hz = m_hazard();
    if (bus.w_en1 && int'(bus.w_addr1) != NR - 1) m_reg[bus.w_addr1] = bus.w_data1;
    if (bus.w_en_ldr && int'(bus.w_addr_ldr) != NR - 1) m_reg[bus.w_addr_ldr] = bus.w_data_ldr;
    if (bus.w_en_ldr) m_busy[bus.w_addr_ldr] = 1'b0;
    if (bus.ldr_issue && int'(bus.ldr_issue_addr) != NR - 1) m_busy[bus.ldr_issue_addr] = 1'b1;
    if (bus.load_pc) begin
      if (bus.sel_pc == PC_START) m_pc = int'(bus.start_pc);
      else if (bus.sel_pc == PC_BRANCH) m_pc = int'(bus.dp_pc);
      else if (!hz) m_pc = (m_pc + 1) % PCM;
    end
    if (bus.en_status) begin
      for (int b = 0; b < 4; b++) if (bus.status_mask[b]) m_st[FLAG_V + b] = bus.status_in[FLAG_V + b];
      m_st[FLAG_V-1:0] = bus.status_in[FLAG_V-1:0];
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_all();
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic idle();
    bus.w_en1 = 0; bus.w_addr1 = '0; bus.w_data1 = '0;
    bus.w_en_ldr = 0; bus.w_addr_ldr = '0; bus.w_data_ldr = '0;
    bus.ldr_issue = 0; bus.ldr_issue_addr = '0;
    bus.rd_addr = '0; bus.rd_used = '0;
    bus.load_pc = 0; bus.sel_pc = PC_INC; bus.start_pc = '0; bus.dp_pc = '0;
    bus.en_status = 0; bus.status_mask = '0; bus.status_in = '0; bus.dbg_addr = '0;
  endtask

  initial begin
    logic [6:0] p;
    idle();
    model_reset();
    bus.rd_used = '1;
    #12;
    check("rst_pc", 64'(bus.pc_out), 64'h0);
    check("rst_status", 64'(bus.status_out), 64'h0);
    check("rst_hazard", 64'(bus.hazard), 64'h0);
    check("rst_r0", 64'(bus.rd_data[31:0]), 64'h0);
    rst_n = 1'b1;
    idle();
    @(posedge clk);
    #1;
    // PC increments and wraps 127 -> 0
    bus.load_pc = 1;
    bus.sel_pc = PC_INC;
    for (int i = 1; i <= 130; i++) begin
      tick();
      if (i == 127) check("pc_127", 64'(bus.pc_out), 64'd127);
      if (i == 128) check("pc_wrap", 64'(bus.pc_out), 64'd0);
    end
    check("pc_130", 64'(bus.pc_out), 64'd2);
    idle();
    // Both ports hit R3: load data wins, bypassed in the same cycle
    bus.w_en1 = 1; bus.w_addr1 = 4'd3; bus.w_data1 = 32'h11;
    bus.w_en_ldr = 1; bus.w_addr_ldr = 4'd3; bus.w_data_ldr = 32'h22;
    bus.rd_addr[3:0] = 4'd3;
    #1;
    check("r3_bypass", 64'(bus.rd_data[31:0]), 64'h22);
    tick();
    bus.w_en1 = 0; bus.w_en_ldr = 0; bus.dbg_addr = 5'd3;
    #1;
    check("r3_stored", 64'(bus.rd_data[31:0]), 64'h22);
    check("r3_dbg", 64'(bus.dbg_data), 64'h22);
    idle();
    // Pending load on R5 stalls increment but not redirect
    bus.ldr_issue = 1; bus.ldr_issue_addr = 4'd5;
    tick();
    idle();
    bus.rd_addr[3:0] = 4'd5; bus.rd_used = 4'b0001; bus.load_pc = 1; bus.sel_pc = PC_INC;
    #1;
    check("r5_hazard", 64'(bus.hazard), 64'h1);
    check("r5_busy", 64'(bus.rd_busy), 64'h1);
    p = bus.pc_out;
    tick();
    check("pc_stall", 64'(bus.pc_out), 64'(p));
    bus.sel_pc = PC_START; bus.start_pc = 7'h55;
    tick();
    check("pc_redirect", 64'(bus.pc_out), 64'h55);
    bus.sel_pc = PC_INC; bus.w_en_ldr = 1; bus.w_addr_ldr = 4'd5; bus.w_data_ldr = 32'h99;
    #1;
    check("r5_hz_hold", 64'(bus.hazard), 64'h1);
    tick();
    bus.w_en_ldr = 0;
    #1;
    check("r5_hz_clear", 64'(bus.hazard), 64'h0);
    check("pc_held", 64'(bus.pc_out), 64'h55);
    check("r5_data", 64'(bus.rd_data[31:0]), 64'h99);
    tick();
    check("pc_resume", 64'(bus.pc_out), 64'h56);
    idle();
    // Masked status load from zero
    bus.en_status = 1; bus.status_mask = 4'b0100; bus.status_in = 32'hF000_0001;
    tick();
    idle();
    #1;
    check("status_mask", 64'(bus.status_out), 64'h4000_0001);
    // Writes to the PC index are dropped
    bus.w_en1 = 1; bus.w_addr1 = 4'd15; bus.w_data1 = 32'hDEAD;
    bus.rd_addr[7:4] = 4'd15;
    #1;
    check("r15_same", 64'(bus.rd_data[63:32]), 64'h56);
    tick();
    idle();
    bus.rd_addr[7:4] = 4'd15; bus.dbg_addr = 5'd15;
    #1;
    check("r15_pc", 64'(bus.rd_data[63:32]), 64'h56);
    check("dbg_pc", 64'(bus.dbg_data), 64'h56);
    bus.dbg_addr = 5'd16;
    #1;
    check("dbg_status", 64'(bus.dbg_data), 64'h4000_0001);
    bus.dbg_addr = 5'd17;
    #1;
    check("dbg_zero", 64'(bus.dbg_data), 64'h0);
    idle();
    // Asynchronous reset between edges with R2 pending
    bus.ldr_issue = 1; bus.ldr_issue_addr = 4'd2;
    tick();
    idle();
    bus.rd_addr[3:0] = 4'd2; bus.rd_used = 4'b0001; bus.dbg_addr = 5'd3;
    #1;
    check("r2_hazard", 64'(bus.hazard), 64'h1);
    rst_n = 1'b0;
    #1;
    check("arst_hazard", 64'(bus.hazard), 64'h0);
    check("arst_pc", 64'(bus.pc_out), 64'h0);
    check("arst_status", 64'(bus.status_out), 64'h0);
    check("arst_r3", 64'(bus.dbg_data), 64'h0);
    model_reset();
    #1;
    rst_n = 1'b1;
    bus.w_en_ldr = 1; bus.w_addr_ldr = 4'd2; bus.w_data_ldr = 32'h77;
    tick();
    bus.w_en_ldr = 0; bus.dbg_addr = 5'd2;
    #1;
    check("post_rst_r2", 64'(bus.dbg_data), 64'h77);
    check("post_rst_hz", 64'(bus.hazard), 64'h0);
    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      bus.w_en1 = 1'($urandom_range(0, 1));
      bus.w_addr1 = 4'($urandom_range(0, 15));
      bus.w_data1 = $urandom;
      bus.w_en_ldr = 1'($urandom_range(0, 1));
      bus.w_addr_ldr = 4'($urandom_range(0, 15));
      bus.w_data_ldr = $urandom;
      bus.ldr_issue = $urandom_range(0, 3) == 0;
      bus.ldr_issue_addr = 4'($urandom_range(0, 15));
      bus.rd_addr = 16'($urandom);
      bus.rd_used = 4'($urandom);
      bus.load_pc = $urandom_range(0, 3) != 0;
      bus.sel_pc = 2'($urandom);
      bus.start_pc = 7'($urandom);
      bus.dp_pc = 7'($urandom);
      bus.en_status = 1'($urandom_range(0, 1));
      bus.status_mask = 4'($urandom);
      bus.status_in = $urandom;
      bus.dbg_addr = 5'($urandom_range(0, 31));
      tick();
    end
    idle();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
